// File: rtl/cvu_pkg.sv
// Shared types and default sizing for the control-vector unit.
package cvu_pkg;

  localparam int CVU_BATCH_W   = 64;
  localparam int CVU_BASE_W    = 4;
  localparam int CVU_NUM_SLOTS = 2;
  localparam int CVU_BB_W      = 5;
  localparam int CVU_CNT_W     = 11;

  // Batch record at the default sizing; the engine declares its own copy
  // sized from its parameters.
  typedef struct packed {
    logic [CVU_BASE_W-1:0]  base;
    logic [CVU_BATCH_W-1:0] bitmap;
    logic [CVU_BB_W-1:0]    bb;
  } batch_slot_t;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_ACCUM  = 2'd1,
    T_FLUSH0 = 2'd2,
    T_FLUSH1 = 2'd3
  } term_state_e;

endpackage

// File: rtl/cvu_first_one.sv
// Lowest-set-bit encoder: index, any-bit flag, and the input with that bit cleared.
module cvu_first_one #(
  parameter int  W  = 64,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o,
  output logic [W-1:0]  cleared_o
);

  always_comb begin
    idx_o = '0;
    for (int i = W-1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign found_o   = |vec_i;
  assign cleared_o = vec_i & (vec_i - W'(1));

endmodule

// File: rtl/cvu_batch_engine.sv
// Control-vector unit: init FIFO with find-first-one thread issue, plus the
// terminate-token accumulator/flush FSM. Define CVU_STATS_EN for statistics ports.
module cvu_batch_engine
  import cvu_pkg::*;
#(
  parameter int  BATCH_W   = CVU_BATCH_W,
  parameter int  BASE_W    = CVU_BASE_W,
  parameter int  NUM_SLOTS = CVU_NUM_SLOTS,
  parameter int  BB_W      = CVU_BB_W,
  parameter int  CNT_W     = CVU_CNT_W,
  localparam int IDX_W     = $clog2(BATCH_W),
  localparam int TID_W     = BASE_W + IDX_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [BASE_W-1:0]  in_base_i,
  input  logic [BATCH_W-1:0] in_bitmap_i,
  input  logic [BB_W-1:0]    in_bb_i,
  output logic               tid_valid_o,
  input  logic               tid_ready_i,
  output logic [TID_W-1:0]   tid_o,
  output logic [BB_W-1:0]    tid_bb_o,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [BB_W-1:0]    cfg_bb0_i,
  input  logic [BB_W-1:0]    cfg_bb1_i,
  input  logic [CNT_W-1:0]   cfg_count_i,
  input  logic               tok_valid_i,
  output logic               tok_ready_o,
  input  logic [TID_W-1:0]   tok_tid_i,
  input  logic               tok_ctrl_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BATCH_W-1:0] out_bitmap_o,
  output logic [BASE_W-1:0]  out_base_o,
  output logic [BB_W-1:0]    out_bb_o
`ifdef CVU_STATS_EN
  ,
  output logic [31:0]        stat_issued_o,
  output logic [31:0]        stat_diverged_o
`endif
);

  localparam int PTR_W = $clog2(NUM_SLOTS);

  typedef struct packed {
    logic [BASE_W-1:0]  base;
    logic [BATCH_W-1:0] bitmap;
    logic [BB_W-1:0]    bb;
  } slot_t;

  // ---------------- init FIFO / issue path ----------------
  slot_t              slots_q [NUM_SLOTS];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     fill_q, fill_d;
  slot_t              head;
  logic [IDX_W-1:0]   ffo_idx;
  logic               ffo_found;
  logic [BATCH_W-1:0] ffo_cleared;
  logic               push, issue, pop;

  assign head = slots_q[rd_ptr_q];

  cvu_first_one #(.W(BATCH_W)) u_ffo (
    .vec_i     (head.bitmap),
    .idx_o     (ffo_idx),
    .found_o   (ffo_found),
    .cleared_o (ffo_cleared)
  );

  // Issue writes back the cleared mask, so a popped or never-filled head
  // slot always holds an empty bitmap: found doubles as "not empty".
  assign tid_valid_o = ffo_found;
  assign in_ready_o  = (fill_q != (PTR_W+1)'(NUM_SLOTS));
  assign tid_o       = tid_valid_o ? {head.base, ffo_idx} : '0;
  assign tid_bb_o    = tid_valid_o ? head.bb : '0;

  assign push  = in_valid_i & in_ready_o & (|in_bitmap_i);
  assign issue = tid_valid_o & tid_ready_i;
  assign pop   = issue & ~(|ffo_cleared);

  always_comb begin
    fill_d = fill_q;
    if (push && !pop)      fill_d = fill_q + (PTR_W+1)'(1);
    else if (!push && pop) fill_d = fill_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (issue) slots_q[rd_ptr_q].bitmap <= ffo_cleared;
      if (push) begin
        slots_q[wr_ptr_q] <= '{base: in_base_i, bitmap: in_bitmap_i, bb: in_bb_i};
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fill_q <= fill_d;
    end
  end

  // ---------------- terminate path ----------------
  term_state_e        state_q, state_d;
  logic [BB_W-1:0]    bb0_q, bb0_d, bb1_q, bb1_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [BATCH_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic               base_vld_q, base_vld_d;
  logic [BASE_W-1:0]  tok_base;
  logic [BATCH_W-1:0] tok_bit;
  logic               base_mis, finish;

  assign tok_base = tok_tid_i[TID_W-1:IDX_W];
  assign tok_bit  = BATCH_W'(1) << tok_tid_i[IDX_W-1:0];
  assign base_mis = base_vld_q && (tok_base != base_q);

  always_comb begin
    state_d      = state_q;
    bb0_d        = bb0_q;
    bb1_d        = bb1_q;
    remain_d     = remain_q;
    acc0_d       = acc0_q;
    acc1_d       = acc1_q;
    base_d       = base_q;
    base_vld_d   = base_vld_q;
    cfg_ready_o  = 1'b0;
    tok_ready_o  = 1'b0;
    out_valid_o  = 1'b0;
    out_bitmap_o = '0;
    out_base_o   = '0;
    out_bb_o     = '0;
    finish       = 1'b0;
    case (state_q)
      T_IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i && cfg_count_i != '0) begin
          bb0_d      = cfg_bb0_i;
          bb1_d      = cfg_bb1_i;
          remain_d   = cfg_count_i;
          acc0_d     = '0;
          acc1_d     = '0;
          base_vld_d = 1'b0;
          state_d    = T_ACCUM;
        end
      end
      T_ACCUM: begin
        tok_ready_o = !base_mis;
        if (tok_valid_i) begin
          if (base_mis) begin
            state_d = T_FLUSH0;
          end else begin
            if (tok_ctrl_i) acc1_d = acc1_q | tok_bit;
            else            acc0_d = acc0_q | tok_bit;
            base_d     = tok_base;
            base_vld_d = 1'b1;
            remain_d   = remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) state_d = T_FLUSH0;
          end
        end
      end
      T_FLUSH0, T_FLUSH1: begin
        // An empty accumulator falls through to the next one in the same cycle.
        if (state_q == T_FLUSH0 && acc0_q != '0) begin
          out_valid_o  = 1'b1;
          out_bitmap_o = acc0_q;
          out_base_o   = base_q;
          out_bb_o     = bb0_q;
          if (out_ready_i) begin
            if (acc1_q != '0) state_d = T_FLUSH1;
            else              finish  = 1'b1;
          end
        end else if (acc1_q != '0) begin
          out_valid_o  = 1'b1;
          out_bitmap_o = acc1_q;
          out_base_o   = base_q;
          out_bb_o     = bb1_q;
          finish       = out_ready_i;
        end else begin
          finish = 1'b1;
        end
        if (finish) begin
          if (remain_q == '0) begin
            state_d = T_IDLE;
          end else begin
            acc0_d     = '0;
            acc1_d     = '0;
            base_vld_d = 1'b0;
            state_d    = T_ACCUM;
          end
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= T_IDLE;
      bb0_q      <= '0;
      bb1_q      <= '0;
      remain_q   <= '0;
      acc0_q     <= '0;
      acc1_q     <= '0;
      base_q     <= '0;
      base_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bb0_q      <= bb0_d;
      bb1_q      <= bb1_d;
      remain_q   <= remain_d;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      base_q     <= base_d;
      base_vld_q <= base_vld_d;
    end
  end

`ifdef CVU_STATS_EN
  logic [31:0] stat_issued_q, stat_diverged_q;
  logic        div_fire;

  // FLUSH1 is only reached after acc0 was emitted with acc1 still pending.
  assign div_fire = out_valid_o & out_ready_i & (state_q == T_FLUSH1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_issued_q   <= '0;
      stat_diverged_q <= '0;
    end else begin
      if (issue && stat_issued_q != '1)      stat_issued_q   <= stat_issued_q + 32'd1;
      if (div_fire && stat_diverged_q != '1) stat_diverged_q <= stat_diverged_q + 32'd1;
    end
  end

  assign stat_issued_o   = stat_issued_q;
  assign stat_diverged_o = stat_diverged_q;
`else
  // statistics compiled out
`endif

endmodule
